circle_buf_mc: RTL and testbench
================================

# circle_buf_mc

Multi-channel, multi-bank triggered capture buffer: the single-clock successor to the team's double-buffered circular capture block. It continuously records `nch` channels into a `2^nb_log`-bank ring of `2^aw`-sample records, positions each trigger `pre_count` samples into its record, and latches a per-record timestamp. It also counts triggers dropped for lack of a free bank. It sits between the ADC sample stream and the local-bus/DMA readout.

## Interface
- `aw`, 10: log2 samples per record (bank).
- `dw`, 16: bits per channel sample.
- `nch`, 4: channel count; the memory word is `nch*dw` bits, channel 0 in the LSBs.
- `nb_log`, 2: log2 bank count; legal range is 1..3.
- `clk`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high.
- `data_w`  in  nch*dw: sample word.
- `stb_w`  in  1: sample valid.
- `trig_ext`  in  1: external trigger, level-sampled on `stb_w`.
- `trig_sw`  in  1: software trigger pulse.
- `mode`  in  2: trigger source. 0 = free-run, 1 = external, 2 = software, 3 = external OR software.
- `pre_count`  in  aw: pre-trigger samples per record; quasi-static, sampled at record start.
- `stb_r`  in  1: read strobe.
- `rewind`  in  1: restart the current read bank at address 0.
- `data_r`  out  nch*dw: read data.
- `data_gate_out`  out  1: `data_r` valid.
- `r_addr`  out  aw: logical read index within the record.
- `ts_r`  out  32: timestamp of the record being read.
- `trig_out`  out  1: one-cycle pulse on each accepted trigger.
- `full_flag`, `empty_flag`, `r_bank_available`  out  1 each.
- `buf_count`  out  16: committed records, wrapping.
- `drop_count`  out  16: rejected triggers, saturating.
- `buf_stat`  out  16: `{r_bank[3:0], w_bank[3:0], nfull[3:0], 2'b0, state[1:0]}`.

## Operation
- Write FSM states:
  - **FILL**: write continuously; count accepted samples up to `pre_count`; triggers are rejected. When the count reaches `pre_count`, go to ARMED. If `pre_count` = 0, enter ARMED directly.
  - **ARMED**: write circularly. A trigger is qualified only with `stb_w`. Mode 0 triggers on the first accepted sample in ARMED. On the trigger sample:
    - `start[w_bank] <= w_addr - pre_count` (mod `2^aw`);
    - `ts[w_bank] <= sample_ctr`;
    - `trig_out` pulses;
    - go to POST with `post_left = 2^aw - pre_count - 1`.
  - **POST**: write and decrement `post_left`. The sample written when `post_left` = 0 commits the bank: `nfull++`, `buf_count++`, `w_bank++` (mod banks), `w_addr <= 0`. The next state is FILL if a bank is free after the commit, otherwise DONE.
  - **DONE**: no writes. Triggers are rejected. On a bank release, go to FILL the next cycle.
- A rejected trigger increments `drop_count`. Rejected means: an ext/sw trigger per `mode` arriving with `stb_w` in FILL or DONE. Mode 0 never drops.
- `sample_ctr` is 32 bits and increments on every `stb_w` in every state, wrapping.
- Read side:
  - `r_en = stb_r & (nfull != 0) & ~rewind`.
  - Memory address is `{r_bank, r_addr + start[r_bank]}`.
  - `r_addr` increments on `r_en`. `r_en` at `r_addr = 2^aw-1` releases the bank: `nfull--`, `r_bank++`, `r_addr` wraps to 0.
  - `rewind` forces `r_addr <= 0` and has priority over `stb_r`.
- Simultaneous commit and release in one cycle: `nfull` is unchanged and the freed bank counts as free for that commit's next-state decision.
- Flags: `full_flag = (nfull == 2^nb_log)`; `empty_flag = (nfull == 0)`; `r_bank_available = ~empty_flag`.
- `stb_r` while empty has no effect.

## Timing
- Read latency is 1: `data_gate_out <= r_en`. `data_r` shows memory output while `data_gate_out` = 1 and holds its last valid value otherwise.
- Commit is visible on flags and `buf_count` the cycle after the last POST sample.
- The trigger sample sits at logical read index `pre_count`.
- Reset values:
  - all outputs 0 except `empty_flag` = 1;
  - state FILL;
  - all pointers, counters, `start[]` and `ts[]` cleared.
- Reset mid-capture or mid-read discards every record.

## Structure
- Package `circle_buf_mc_pkg` holds the FSM state encodings (FILL=0, ARMED=1, POST=2, DONE=3) and the mode constants.
- `start[]` and `ts[]` are small register arrays indexed by bank.
- One sub-module: the existing `dpram`, with `aw = aw + nb_log`, `dw = nch*dw`, and both clocks tied to `clk`.

## Test plan
All scenarios use `aw=4`, `nch=2`, `dw=8`, `nb_log=1` unless stated.

1. **Mode 1, single capture.** Stimulus: `pre_count=4`, ramp data 0,1,2,…, `trig_ext` on sample 10. Response: one record commits after sample 21; reading yields 6..21; `ts_r=10`; `trig_out` is a single pulse.
2. **Trigger too early.** Stimulus: mode 1, `pre_count=8`, `trig_ext` on sample 3. Response: `drop_count=1`, no `trig_out`; a later trigger on sample 12 captures 4..19.
3. **Bank overrun.** Stimulus: mode 0, continuous `stb_w`, no reads. Response: two records commit, `full_flag=1`, state DONE; each further mode-3 `trig_sw` increments `drop_count`.
4. **Commit and release in the same cycle.** Stimulus: `nb_log=2`, reader releasing in the same cycle as a write commit. Response: `nfull` steady, FSM goes to FILL, no drops.
5. **Rewind mid-read.** Stimulus: assert `rewind` at `r_addr=7`. Response: `r_addr=0`, the next reads repeat from the trigger-relative start, `nfull` unchanged.
6. **Reset during POST.** Stimulus: assert `reset` while in POST. Response: `empty_flag=1`, `buf_count=0`, `drop_count=0`, `ts_r=0`, state FILL.

Source files
------------

// File: rtl/circle_buf_mc_pkg.sv
// Shared encodings for the multi-bank triggered capture buffer.
// Holds the write FSM states, trigger-source modes and trigger qualification.
package circle_buf_mc_pkg;

  localparam logic [1:0] StFill  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StPost  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] ModeFree = 2'd0;
  localparam logic [1:0] ModeExt  = 2'd1;
  localparam logic [1:0] ModeSw   = 2'd2;
  localparam logic [1:0] ModeBoth = 2'd3;

  // External/software trigger request for the selected source; free-run never requests.
  function automatic logic trig_qual(input logic [1:0] mode, input logic ext, input logic sw);
    case (mode)
      ModeExt:  return ext;
      ModeSw:   return sw;
      ModeBoth: return ext | sw;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/circle_buf_mc_dpram.sv
// Simple dual-port RAM: synchronous write on port A, registered read on port B.
// Read output holds its value while renb is low.
module dpram #(
  parameter int aw = 8,
  parameter int dw = 8
) (
  input  logic          clka,
  input  logic          clkb,
  input  logic [aw-1:0] addra,
  input  logic [dw-1:0] dina,
  input  logic          wena,
  input  logic [aw-1:0] addrb,
  input  logic          renb,
  output logic [dw-1:0] doutb
);

  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clka) begin
    if (wena) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (renb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/circle_buf_mc.sv
// Multi-channel, multi-bank triggered capture buffer with per-record timestamps.
// Writes a ring of banks around each trigger; the reader drains committed banks in order.
module circle_buf_mc
  import circle_buf_mc_pkg::*;
#(
  parameter int aw     = 10,
  parameter int dw     = 16,
  parameter int nch    = 4,
  parameter int nb_log = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [nch*dw-1:0] data_w,
  input  logic              stb_w,
  input  logic              trig_ext,
  input  logic              trig_sw,
  input  logic [1:0]        mode,
  input  logic [aw-1:0]     pre_count,
  input  logic              stb_r,
  input  logic              rewind,
  output logic [nch*dw-1:0] data_r,
  output logic              data_gate_out,
  output logic [aw-1:0]     r_addr,
  output logic [31:0]       ts_r,
  output logic              trig_out,
  output logic              full_flag,
  output logic              empty_flag,
  output logic              r_bank_available,
  output logic [15:0]       buf_count,
  output logic [15:0]       drop_count,
  output logic [15:0]       buf_stat
);

  localparam int mw     = nch * dw;
  localparam int nbanks = 1 << nb_log;

  logic [1:0]        state, state_d, st_eff;
  logic [aw-1:0]     w_addr, w_addr_d, post_left, post_left_d, pre_q, pre_eff, r_phys;
  logic [nb_log-1:0] w_bank, r_bank;
  logic [3:0]        nfull, nfull_after;
  logic [31:0]       sample_ctr;
  logic [aw-1:0]     start [nbanks];
  logic [31:0]       ts [nbanks];
  logic [mw-1:0]     dout, data_hold;
  logic              trig_req, trig_hit, commit, drop, rel, r_en, we;

  always_comb begin
    // pre_count is live until the record's first sample, then frozen in pre_q
    pre_eff  = (state == StFill && w_addr == '0) ? pre_count : pre_q;
    st_eff   = (state == StFill && pre_eff == '0) ? StArmed : state;
    trig_req = trig_qual(mode, trig_ext, trig_sw);
    r_en     = stb_r & (nfull != 4'd0) & ~rewind;
    rel      = r_en & (r_addr == {aw{1'b1}});
    we       = stb_w & (state != StDone);

    state_d     = state;
    w_addr_d    = w_addr;
    post_left_d = post_left;
    trig_hit    = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;

    unique case (st_eff)
      StFill: begin
        if (stb_w) begin
          w_addr_d = w_addr + 1'b1;
          if (w_addr_d == pre_eff) state_d = StArmed;
          drop = trig_req;
        end
      end
      StArmed: begin
        if (stb_w) begin
          w_addr_d = w_addr + 1'b1;
          trig_hit = (mode == ModeFree) | trig_req;
          if (trig_hit) begin
            post_left_d = ~pre_eff;
            if (post_left_d == '0) commit = 1'b1;
            else state_d = StPost;
          end
        end
      end
      StPost: begin
        if (stb_w) begin
          w_addr_d    = w_addr + 1'b1;
          post_left_d = post_left - 1'b1;
          commit      = (post_left_d == '0);
        end
      end
      StDone: begin
        if (rel) state_d = StFill;
        drop = stb_w & trig_req;
      end
    endcase

    nfull_after = nfull + {3'b000, commit} - {3'b000, rel};
    if (commit) begin
      w_addr_d = '0;
      state_d  = (nfull_after == 4'(nbanks)) ? StDone : StFill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StFill;
      w_addr        <= '0;
      post_left     <= '0;
      pre_q         <= '0;
      w_bank        <= '0;
      r_bank        <= '0;
      r_addr        <= '0;
      nfull         <= '0;
      sample_ctr    <= '0;
      trig_out      <= 1'b0;
      buf_count     <= '0;
      drop_count    <= '0;
      data_gate_out <= 1'b0;
      data_hold     <= '0;
      for (int b = 0; b < nbanks; b++) begin
        start[b] <= '0;
        ts[b]    <= '0;
      end
    end else begin
      state     <= state_d;
      w_addr    <= w_addr_d;
      post_left <= post_left_d;
      if (state == StFill && w_addr == '0) pre_q <= pre_count;
      if (stb_w) sample_ctr <= sample_ctr + 32'd1;
      trig_out <= trig_hit;
      if (trig_hit) begin
        start[w_bank] <= w_addr - pre_eff;
        ts[w_bank]    <= sample_ctr;
      end
      if (commit) begin
        w_bank    <= w_bank + 1'b1;
        buf_count <= buf_count + 16'd1;
      end
      if (drop && drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
      nfull <= nfull_after;
      if (rewind) r_addr <= '0;
      else if (r_en) r_addr <= r_addr + 1'b1;
      if (rel) r_bank <= r_bank + 1'b1;
      data_gate_out <= r_en;
      if (data_gate_out) data_hold <= dout;
    end
  end

  assign r_phys = r_addr + start[r_bank];

  dpram #(
    .aw(aw + nb_log),
    .dw(mw)
  ) u_dpram (
    .clka (clk),
    .clkb (clk),
    .addra({w_bank, w_addr}),
    .dina (data_w),
    .wena (we),
    .addrb({r_bank, r_phys}),
    .renb (r_en),
    .doutb(dout)
  );

  assign data_r           = data_gate_out ? dout : data_hold;
  assign ts_r             = ts[r_bank];
  assign full_flag        = (nfull == 4'(nbanks));
  assign empty_flag       = (nfull == 4'd0);
  assign r_bank_available = ~empty_flag;
  assign buf_stat         = {4'(r_bank), 4'(w_bank), nfull, 2'b00, state};

endmodule

// File: tb/tb_circle_buf_mc.sv
// Directed bench for circle_buf_mc: two-bank instance for most scenarios and a
// four-bank instance sharing the same stimulus for the commit/release overlap case.
module tb_circle_buf_mc;

  logic        clk = 1'b0;
  logic        reset, stb_w, trig_ext, trig_sw, stb_r, rewind;
  logic [15:0] data_w;
  logic [1:0]  mode;
  logic [3:0]  pre_count;

  logic [15:0] data_r, buf_count, drop_count, buf_stat;
  logic        data_gate_out, trig_out, full_flag, empty_flag, r_bank_available;
  logic [3:0]  r_addr;
  logic [31:0] ts_r;

  logic [15:0] q_data_r, q_buf_count, q_drop_count, q_buf_stat;
  logic        q_data_gate_out, q_trig_out, q_full_flag, q_empty_flag, q_r_bank_available;
  logic [3:0]  q_r_addr;
  logic [31:0] q_ts_r;

  int n_cmp = 0;
  int n_bad = 0;
  int n_trig;
  int trig_at;

  always #5 clk = ~clk;

  circle_buf_mc #(.aw(4), .dw(8), .nch(2), .nb_log(1)) u_dut (
    .clk(clk), .reset(reset), .data_w(data_w), .stb_w(stb_w), .trig_ext(trig_ext),
    .trig_sw(trig_sw), .mode(mode), .pre_count(pre_count), .stb_r(stb_r), .rewind(rewind),
    .data_r(data_r), .data_gate_out(data_gate_out), .r_addr(r_addr), .ts_r(ts_r),
    .trig_out(trig_out), .full_flag(full_flag), .empty_flag(empty_flag),
    .r_bank_available(r_bank_available), .buf_count(buf_count), .drop_count(drop_count),
    .buf_stat(buf_stat)
  );

  circle_buf_mc #(.aw(4), .dw(8), .nch(2), .nb_log(2)) u_dut4 (
    .clk(clk), .reset(reset), .data_w(data_w), .stb_w(stb_w), .trig_ext(trig_ext),
    .trig_sw(trig_sw), .mode(mode), .pre_count(pre_count), .stb_r(stb_r), .rewind(rewind),
    .data_r(q_data_r), .data_gate_out(q_data_gate_out), .r_addr(q_r_addr), .ts_r(q_ts_r),
    .trig_out(q_trig_out), .full_flag(q_full_flag), .empty_flag(q_empty_flag),
    .r_bank_available(q_r_bank_available), .buf_count(q_buf_count),
    .drop_count(q_drop_count), .buf_stat(q_buf_stat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stb_w = 1'b0; stb_r = 1'b0; rewind = 1'b0;
    trig_ext = 1'b0; trig_sw = 1'b0; data_w = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] sample(input int v);
    return {8'(v + 128), 8'(v)};
  endfunction

  // Stream samples 0..n-1 (data = sample(k)) with trig_ext high on samples t1 and t2.
  task automatic push_samples(input int n, input int t1, input int t2);
    n_trig  = 0;
    trig_at = -1;
    for (int k = 0; k < n; k++) begin
      stb_w    = 1'b1;
      data_w   = sample(k);
      trig_ext = (k == t1) || (k == t2);
      tick();
      if (trig_out) begin
        n_trig++;
        trig_at = k;
      end
    end
    stb_w    = 1'b0;
    trig_ext = 1'b0;
  endtask

  task automatic read_check(input int n, input int first, input string tag);
    for (int i = 0; i < n; i++) begin
      stb_r = 1'b1;
      tick();
      check_eq({tag, "_gate"}, 32'(data_gate_out), 32'd1);
      check_eq({tag, "_data"}, 32'(data_r), 32'(sample(first + i)));
    end
    stb_r = 1'b0;
  endtask

  initial begin
    mode = 2'd1;
    pre_count = 4'd4;
    do_reset();
    check_eq("rst_empty", 32'(empty_flag), 32'd1);
    check_eq("rst_full", 32'(full_flag), 32'd0);
    check_eq("rst_avail", 32'(r_bank_available), 32'd0);
    check_eq("rst_stat", 32'(buf_stat), 32'h0000);
    check_eq("rst_bufcnt", 32'(buf_count), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_ts", ts_r, 32'd0);
    check_eq("rst_gate", 32'(data_gate_out), 32'd0);
    check_eq("rst_data", 32'(data_r), 32'd0);

    // Single capture, then rewind partway through the read.
    push_samples(22, 10, -1);
    check_eq("t1_ntrig", 32'(n_trig), 32'd1);
    check_eq("t1_trigat", 32'(trig_at), 32'd10);
    check_eq("t1_bufcnt", 32'(buf_count), 32'd1);
    check_eq("t1_stat", 32'(buf_stat), 32'h0110);
    check_eq("t1_ts", ts_r, 32'd10);
    check_eq("t1_avail", 32'(r_bank_available), 32'd1);
    read_check(7, 6, "t5_pre");
    check_eq("t5_raddr7", 32'(r_addr), 32'd7);
    rewind = 1'b1;
    stb_r  = 1'b1;
    tick();
    rewind = 1'b0;
    stb_r  = 1'b0;
    check_eq("t5_raddr0", 32'(r_addr), 32'd0);
    check_eq("t5_gate", 32'(data_gate_out), 32'd0);
    check_eq("t5_stat", 32'(buf_stat), 32'h0110);
    read_check(16, 6, "t1_rd");
    tick();
    check_eq("t1_gate_off", 32'(data_gate_out), 32'd0);
    check_eq("t1_hold", 32'(data_r), 32'(sample(21)));
    check_eq("t1_empty", 32'(empty_flag), 32'd1);
    check_eq("t1_stat_end", 32'(buf_stat), 32'h1100);

    // Trigger during FILL is dropped; the later one captures.
    pre_count = 4'd8;
    do_reset();
    push_samples(20, 3, 12);
    check_eq("t2_drop", 32'(drop_count), 32'd1);
    check_eq("t2_ntrig", 32'(n_trig), 32'd1);
    check_eq("t2_trigat", 32'(trig_at), 32'd12);
    check_eq("t2_ts", ts_r, 32'd12);
    check_eq("t2_bufcnt", 32'(buf_count), 32'd1);
    read_check(16, 4, "t2_rd");

    // Free-run overrun into DONE, then drops on software triggers.
    mode = 2'd0;
    pre_count = 4'd4;
    do_reset();
    push_samples(32, -1, -1);
    check_eq("t3_ntrig", 32'(n_trig), 32'd2);
    check_eq("t3_full", 32'(full_flag), 32'd1);
    check_eq("t3_stat", 32'(buf_stat), 32'h0023);
    check_eq("t3_bufcnt", 32'(buf_count), 32'd2);
    check_eq("t3_drop0", 32'(drop_count), 32'd0);
    mode    = 2'd3;
    trig_sw = 1'b1;
    stb_w   = 1'b1;
    repeat (3) tick();
    trig_sw = 1'b0;
    stb_w   = 1'b0;
    check_eq("t3_drop3", 32'(drop_count), 32'd3);
    check_eq("t3_bufcnt2", 32'(buf_count), 32'd2);
    check_eq("t3_trig", 32'(trig_out), 32'd0);

    // Reader releases bank 0 in the same cycle the second record commits.
    mode = 2'd0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      stb_w  = 1'b1;
      data_w = sample(k);
      stb_r  = (k >= 16);
      tick();
      if (k == 30) check_eq("t4_stat_pre", 32'(q_buf_stat), 32'h0112);
    end
    stb_w = 1'b0;
    stb_r = 1'b0;
    check_eq("t4_stat4", 32'(q_buf_stat), 32'h1210);
    check_eq("t4_bufcnt", 32'(q_buf_count), 32'd2);
    check_eq("t4_drop", 32'(q_drop_count), 32'd0);
    check_eq("t4_stat2", 32'(buf_stat), 32'h1010);
    check_eq("t4_raddr", 32'(q_r_addr), 32'd0);

    // Reset while in POST discards everything.
    mode = 2'd1;
    do_reset();
    push_samples(13, 2, 10);
    check_eq("t6_stat_post", 32'(buf_stat), 32'h0002);
    check_eq("t6_ts_pre", ts_r, 32'd10);
    check_eq("t6_drop_pre", 32'(drop_count), 32'd1);
    do_reset();
    check_eq("t6_empty", 32'(empty_flag), 32'd1);
    check_eq("t6_bufcnt", 32'(buf_count), 32'd0);
    check_eq("t6_drop", 32'(drop_count), 32'd0);
    check_eq("t6_ts", ts_r, 32'd0);
    check_eq("t6_stat", 32'(buf_stat), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
